// File: rtl/vmproj_mem_paged.sv
// Paged dual-port VMPROJ memory: router-side writes and per-page entry counts,
// pipelined read port with a read-valid strobe for the match engine.
module vmproj_mem_paged #(
    parameter int RAM_WIDTH   = 21,
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_PAGES   = 2,
    parameter int PAGE_DEPTH  = 2 ** (ADDR_WIDTH - $clog2(NUM_PAGES)),
    parameter int NENT_WIDTH  = 8,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dataarray_data_V_wea,
    input  logic [ADDR_WIDTH-1:0] dataarray_data_V_writeaddr,
    input  logic [RAM_WIDTH-1:0]  dataarray_data_V_din,
    input  logic                  nentries_0_V_we,
    input  logic [NENT_WIDTH-1:0] nentries_0_V_din,
    input  logic                  nentries_1_V_we,
    input  logic [NENT_WIDTH-1:0] nentries_1_V_din,
    input  logic                  dataarray_data_V_enb,
    input  logic [ADDR_WIDTH-1:0] dataarray_data_V_readaddr,
    output logic [RAM_WIDTH-1:0]  dataarray_data_V_dout,
    output logic                  dataarray_data_V_dout_vld,
    output logic [NENT_WIDTH-1:0] nentries_0_V_dout,
    output logic [NENT_WIDTH-1:0] nentries_1_V_dout
);

    localparam int DEPTH = NUM_PAGES * PAGE_DEPTH;

    logic [RAM_WIDTH-1:0]   mem_q [DEPTH];
    logic [RAM_WIDTH-1:0]   ram_rd_q, ram_rd_d;
    logic [RAM_WIDTH-1:0]   out_q, out_d;
    logic [RAM_LATENCY-1:0] vld_q, vld_d;
    logic [NENT_WIDTH-1:0]  nent0_q, nent0_d;
    logic [NENT_WIDTH-1:0]  nent1_q, nent1_d;

    // Storage is never reset; the router owns its contents, even during reset.
    always_ff @(posedge clk) begin
        if (dataarray_data_V_wea) begin
            mem_q[dataarray_data_V_writeaddr] <= dataarray_data_V_din;
        end
    end

    always_comb begin
        ram_rd_d = ram_rd_q;
        if (dataarray_data_V_enb) begin
            ram_rd_d = mem_q[dataarray_data_V_readaddr];
        end

        vld_d    = '0;
        vld_d[0] = dataarray_data_V_enb;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        out_d = out_q;
        if (vld_q[0]) begin
            out_d = ram_rd_q;
        end

        nent0_d = nent0_q;
        if (nentries_0_V_we) begin
            nent0_d = nentries_0_V_din;
        end
        nent1_d = nent1_q;
        if (nentries_1_V_we) begin
            nent1_d = nentries_1_V_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_rd_q <= '0;
            out_q    <= '0;
            vld_q    <= '0;
            nent0_q  <= '0;
            nent1_q  <= '0;
        end else begin
            ram_rd_q <= ram_rd_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
            nent0_q  <= nent0_d;
            nent1_q  <= nent1_d;
        end
    end

    // With a single stage the RAM register itself is the output register.
    generate
        if (RAM_LATENCY == 1) begin : g_lat1
            assign dataarray_data_V_dout = ram_rd_q;
        end else begin : g_lat2
            assign dataarray_data_V_dout = out_q;
        end
    endgenerate

    assign dataarray_data_V_dout_vld = vld_q[RAM_LATENCY-1];
    assign nentries_0_V_dout         = nent0_q;
    assign nentries_1_V_dout         = nent1_q;

endmodule

// File: tb/tb_vmproj_mem_paged.sv
// Scoreboard bench for vmproj_mem_paged: a latency-2 and a latency-1 instance
// share stimulus; expected reads are queued at issue and retired on dout_vld.
module tb_vmproj_mem_paged;

    typedef struct {
        logic [20:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wea = 1'b0;
    logic [7:0]  waddr = '0;
    logic [20:0] din = '0;
    logic        n0_we = 1'b0;
    logic [7:0]  n0_din = '0;
    logic        n1_we = 1'b0;
    logic [7:0]  n1_din = '0;
    logic        enb = 1'b0;
    logic [7:0]  raddr = '0;

    logic [20:0] dout2, dout1;
    logic        vld2, vld1;
    logic [7:0]  n0_dout2, n1_dout2, n0_dout1, n1_dout1;

    logic [20:0] model [256];
    exp_t        q2[$];
    exp_t        q1[$];
    exp_t        e2, e1;
    int          cycle = 0;
    int          checks = 0;
    int          failures = 0;

    vmproj_mem_paged #(.RAM_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset),
        .dataarray_data_V_wea(wea), .dataarray_data_V_writeaddr(waddr),
        .dataarray_data_V_din(din),
        .nentries_0_V_we(n0_we), .nentries_0_V_din(n0_din),
        .nentries_1_V_we(n1_we), .nentries_1_V_din(n1_din),
        .dataarray_data_V_enb(enb), .dataarray_data_V_readaddr(raddr),
        .dataarray_data_V_dout(dout2), .dataarray_data_V_dout_vld(vld2),
        .nentries_0_V_dout(n0_dout2), .nentries_1_V_dout(n1_dout2)
    );

    vmproj_mem_paged #(.RAM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .dataarray_data_V_wea(wea), .dataarray_data_V_writeaddr(waddr),
        .dataarray_data_V_din(din),
        .nentries_0_V_we(n0_we), .nentries_0_V_din(n0_din),
        .nentries_1_V_we(n1_we), .nentries_1_V_din(n1_din),
        .dataarray_data_V_enb(enb), .dataarray_data_V_readaddr(raddr),
        .dataarray_data_V_dout(dout1), .dataarray_data_V_dout_vld(vld1),
        .nentries_0_V_dout(n0_dout1), .nentries_1_V_dout(n1_dout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (vld2 === 1'b1) begin
            checks++;
            if (q2.size() == 0) begin
                failures++;
                $display("[TB] FAIL lat2_unexpected_vld cycle=%0d got vld=1 expected no pending read", cycle);
            end else begin
                e2 = q2.pop_front();
                checks++;
                if (dout2 !== e2.data) begin
                    failures++;
                    $display("[TB] FAIL lat2_data cycle=%0d got %h expected %h", cycle, dout2, e2.data);
                end
                checks++;
                if (cycle !== e2.cyc) begin
                    failures++;
                    $display("[TB] FAIL lat2_timing got cycle %0d expected cycle %0d", cycle, e2.cyc);
                end
            end
        end else if (q2.size() > 0 && q2[0].cyc <= cycle) begin
            e2 = q2.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL lat2_missing_vld cycle=%0d got vld=%b expected 1", cycle, vld2);
        end
    end

    always @(negedge clk) begin
        if (vld1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("[TB] FAIL lat1_unexpected_vld cycle=%0d got vld=1 expected no pending read", cycle);
            end else begin
                e1 = q1.pop_front();
                checks++;
                if (dout1 !== e1.data) begin
                    failures++;
                    $display("[TB] FAIL lat1_data cycle=%0d got %h expected %h", cycle, dout1, e1.data);
                end
                checks++;
                if (cycle !== e1.cyc) begin
                    failures++;
                    $display("[TB] FAIL lat1_timing got cycle %0d expected cycle %0d", cycle, e1.cyc);
                end
            end
        end else if (q1.size() > 0 && q1[0].cyc <= cycle) begin
            e1 = q1.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL lat1_missing_vld cycle=%0d got vld=%b expected 1", cycle, vld1);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one cycle of inputs and updates the scoreboard/model accordingly.
    task automatic drive(input logic rst, input logic we, input logic [7:0] wa,
                         input logic [20:0] wd, input logic re, input logic [7:0] ra,
                         input logic w0, input logic [7:0] c0,
                         input logic w1, input logic [7:0] c1);
        exp_t e;
        reset  = rst;
        wea    = we;
        waddr  = wa;
        din    = wd;
        enb    = re;
        raddr  = ra;
        n0_we  = w0;
        n0_din = c0;
        n1_we  = w1;
        n1_din = c1;
        if (re && !rst) begin
            e.data = model[ra];
            e.cyc  = cycle + 2;
            q2.push_back(e);
            e.cyc  = cycle + 1;
            q1.push_back(e);
        end
        if (rst) begin
            while (q2.size() > 0 && q2[$].cyc > cycle) void'(q2.pop_back());
            while (q1.size() > 0 && q1[$].cyc > cycle) void'(q1.pop_back());
        end
        if (we) model[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 21'h0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic test_reset();
        int pulses;
        repeat (3) drive(1, 0, 8'h00, 21'h0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        repeat (2) idle();
        checks++;
        if (dout2 !== 21'h0 || vld2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_lat2 got dout=%h vld=%b expected 0/0", dout2, vld2);
        end
        checks++;
        if (dout1 !== 21'h0 || vld1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_lat1 got dout=%h vld=%b expected 0/0", dout1, vld1);
        end
        checks++;
        if (n0_dout2 !== 8'd0 || n1_dout2 !== 8'd0 || n0_dout1 !== 8'd0 || n1_dout1 !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_counts got %0d %0d %0d %0d expected all 0",
                     n0_dout2, n1_dout2, n0_dout1, n1_dout1);
        end
        drive(0, 1, 8'h30, 21'h00077, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        drive(0, 1, 8'h31, 21'h00088, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        drive(0, 0, 8'h00, 21'h0, 1, 8'h30, 0, 8'h00, 0, 8'h00);
        drive(0, 0, 8'h00, 21'h0, 1, 8'h31, 0, 8'h00, 0, 8'h00);
        drive(1, 0, 8'h00, 21'h0, 1, 8'h30, 0, 8'h00, 0, 8'h00);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            #3;
            if (vld2 === 1'b1) pulses++;
            if (vld1 === 1'b1) pulses++;
            idle();
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("[TB] FAIL reset_flush got %0d vld pulses expected 0", pulses);
        end
    endtask

    task automatic test_write_read();
        drive(0, 1, 8'h05, 21'h0ABCD, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        drive(0, 1, 8'h85, 21'h1FFFF, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        drive(0, 0, 8'h00, 21'h0, 1, 8'h05, 0, 8'h00, 0, 8'h00);
        drive(0, 0, 8'h00, 21'h0, 1, 8'h85, 0, 8'h00, 0, 8'h00);
        #3;
        checks++;
        if (dout2 !== 21'h0ABCD || vld2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL read_first got dout=%h vld=%b expected 0abcd/1", dout2, vld2);
        end
        idle();
        #3;
        checks++;
        if (dout2 !== 21'h1FFFF || vld2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL read_second got dout=%h vld=%b expected 1ffff/1", dout2, vld2);
        end
        idle();
        #3;
        checks++;
        if (dout2 !== 21'h1FFFF || vld2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_hold got dout=%h vld=%b expected 1ffff/0", dout2, vld2);
        end
        repeat (3) idle();
    endtask

    task automatic test_counts();
        drive(0, 0, 8'h00, 21'h0, 0, 8'h00, 1, 8'd17, 1, 8'd42);
        checks++;
        if (n0_dout2 !== 8'd17 || n1_dout2 !== 8'd42) begin
            failures++;
            $display("[TB] FAIL count_update got %0d/%0d expected 17/42", n0_dout2, n1_dout2);
        end
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 8'h40 + 8'(i), 21'(i), 0, 8'h00, 0, 8'h00, 0, 8'h00);
        end
        checks++;
        if (n0_dout2 !== 8'd17 || n1_dout2 !== 8'd42 || n0_dout1 !== 8'd17 || n1_dout1 !== 8'd42) begin
            failures++;
            $display("[TB] FAIL count_after_writes got %0d/%0d expected 17/42", n0_dout2, n1_dout2);
        end
        drive(0, 0, 8'h00, 21'h0, 0, 8'h00, 0, 8'd99, 1, 8'd200);
        checks++;
        if (n0_dout2 !== 8'd17 || n1_dout2 !== 8'd200) begin
            failures++;
            $display("[TB] FAIL count_single_page got %0d/%0d expected 17/200", n0_dout2, n1_dout2);
        end
    endtask

    task automatic test_collision();
        drive(0, 1, 8'h10, 21'h00001, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        idle();
        drive(0, 1, 8'h10, 21'h00002, 1, 8'h10, 0, 8'h00, 0, 8'h00);
        drive(0, 0, 8'h00, 21'h0, 1, 8'h10, 0, 8'h00, 0, 8'h00);
        #3;
        checks++;
        if (dout2 !== 21'h00001) begin
            failures++;
            $display("[TB] FAIL collision_old got %h expected 00001", dout2);
        end
        idle();
        #3;
        checks++;
        if (dout2 !== 21'h00002) begin
            failures++;
            $display("[TB] FAIL collision_new got %h expected 00002", dout2);
        end
        repeat (3) idle();
    endtask

    task automatic test_back_to_back();
        int cnt2, cnt1, first2, first1;
        for (int a = 128; a < 256; a++) begin
            drive(0, 1, 8'(a), 21'(a), 0, 8'h00, 0, 8'h00, 0, 8'h00);
        end
        cnt2 = 0; cnt1 = 0; first2 = -1; first1 = -1;
        for (int i = 0; i < 132; i++) begin
            #3;
            if (vld2 === 1'b1) begin
                cnt2++;
                if (first2 < 0) first2 = i;
            end
            if (vld1 === 1'b1) begin
                cnt1++;
                if (first1 < 0) first1 = i;
            end
            if (i < 128) drive(0, 0, 8'h00, 21'h0, 1, 8'(128 + i), 0, 8'h00, 0, 8'h00);
            else idle();
        end
        checks++;
        if (cnt2 !== 128 || cnt1 !== 128) begin
            failures++;
            $display("[TB] FAIL burst_count got %0d/%0d expected 128/128", cnt2, cnt1);
        end
        checks++;
        if (first2 !== 2 || first1 !== 1) begin
            failures++;
            $display("[TB] FAIL burst_latency got %0d/%0d expected 2/1", first2, first1);
        end
    endtask

    task automatic test_reset_write();
        drive(0, 1, 8'h20, 21'h0DEAD, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        drive(1, 1, 8'h20, 21'h12345, 0, 8'h00, 1, 8'd9, 0, 8'h00);
        idle();
        checks++;
        if (n0_dout2 !== 8'd0 || n1_dout2 !== 8'd0 || n0_dout1 !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_strobe got %0d/%0d expected 0/0", n0_dout2, n1_dout2);
        end
        drive(0, 0, 8'h00, 21'h0, 1, 8'h20, 0, 8'h00, 0, 8'h00);
        idle();
        #3;
        checks++;
        if (dout2 !== 21'h12345 || vld2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_write_kept got dout=%h vld=%b expected 12345/1", dout2, vld2);
        end
        repeat (4) idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_counts();
        test_collision();
        test_back_to_back();
        test_reset_write();
        repeat (5) idle();
        checks++;
        if (q2.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("[TB] FAIL pending_reads got %0d/%0d expected 0/0", q2.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
